// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types and constants for the writeback arbiter
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant with a pointer that advances past the last grantee
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic [NUM_REQ-1:0] iReq,
  input  logic               iAdvance,
  output logic [NUM_REQ-1:0] oGrant
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic [PW-1:0] w_idx;

  // Scan from the farthest slot back to the pointer so the nearest valid one wins last.
  always_comb begin
    oGrant = '0;
    w_next = r_ptr;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (iReq[w_idx]) begin
        oGrant        = '0;
        oGrant[w_idx] = 1'b1;
        w_next        = PW'((int'(w_idx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_ptr <= '0;
    end else if (iAdvance) begin
      r_ptr <= w_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with RAW scoreboard
// Optional scoreboard enabled by defining REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH    = REG_DATA_W
) (
  input  logic                                iClk,
  input  logic                                iRstN,
  input  logic [NUM_REQ-1:0]                  iReqValid,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] iReqAddr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    iReqData,
  output logic [NUM_REQ-1:0]                  oReqReady,
  output logic                                oWriteEn,
  output logic [ADDRESS_WIDTH-1:0]            oWriteAddress,
  output logic [DATA_WIDTH-1:0]               oDataIn,
  input  logic                                iIssueValid,
  input  logic [ADDRESS_WIDTH-1:0]            iIssueRd,
  output logic                                oIssueReady,
  input  logic [ADDRESS_WIDTH-1:0]            iQueryAddr1,
  input  logic [ADDRESS_WIDTH-1:0]            iQueryAddr2,
  output logic                                oBusy1,
  output logic                                oBusy2
);

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [NUM_REQ-1:0] w_grant;
  wb_req_t            w_win;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iReq     (iReqValid),
    .iAdvance (w_win.valid),
    .oGrant   (w_arb_grant)
  );

  // Grants are suppressed during reset so in-flight requests are dropped.
  assign w_grant   = w_arb_grant & {NUM_REQ{iRstN}};
  assign oReqReady = w_grant;

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win.valid = 1'b1;
        w_win.addr  = iReqAddr[i];
        w_win.data  = iReqData[i];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oWriteEn      <= 1'b0;
      oWriteAddress <= '0;
      oDataIn       <= '0;
    end else begin
      oWriteEn <= w_win.valid && (w_win.addr != REG_ZERO);
      if (w_win.valid) begin
        oWriteAddress <= w_win.addr;
        oDataIn       <= w_win.data;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [2**ADDRESS_WIDTH-1:0] r_busy;
  logic [2**ADDRESS_WIDTH-1:0] w_busy_next;
  logic                        w_release_rd;

  assign w_release_rd = w_win.valid && (w_win.addr == iIssueRd);
  assign oIssueReady  = iIssueValid && iRstN &&
                        ((iIssueRd == REG_ZERO) || !r_busy[iIssueRd] || w_release_rd);
  assign oBusy1       = r_busy[iQueryAddr1];
  assign oBusy2       = r_busy[iQueryAddr2];

  // Release is applied before the claim so a same-cycle claim of that register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_win.valid) begin
      w_busy_next[w_win.addr] = 1'b0;
    end
    if (oIssueReady) begin
      w_busy_next[iIssueRd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end
`else
  logic w_unused_sb;

  assign w_unused_sb = ^{iIssueRd, iQueryAddr1, iQueryAddr2};
  assign oIssueReady = iIssueValid && iRstN;
  assign oBusy1      = 1'b0;
  assign oBusy2      = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized check of regfile_wb_arbiter against a reference model
module tb_regfile_wb_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N-1:0][4:0] req_addr;
  logic [N-1:0][31:0] req_data;
  logic [N-1:0]      ready;
  logic              we;
  logic [4:0]        waddr;
  logic [31:0]       wdata;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              issue_ready;
  logic [4:0]        q1, q2;
  logic              busy1, busy2;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: pointer, per-register pending flags, expected registered write.
  int        ptr;
  bit [31:0] mbusy;
  bit        exp_we;
  bit [4:0]  exp_addr;
  bit [31:0] exp_data;
  int        wait_cnt [N];
  int        last_g;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .iClk          (clk),
    .iRstN         (rstn),
    .iReqValid     (req_valid),
    .iReqAddr      (req_addr),
    .iReqData      (req_data),
    .oReqReady     (ready),
    .oWriteEn      (we),
    .oWriteAddress (waddr),
    .oDataIn       (wdata),
    .iIssueValid   (issue_valid),
    .iIssueRd      (issue_rd),
    .oIssueReady   (issue_ready),
    .iQueryAddr1   (q1),
    .iQueryAddr2   (q2),
    .oBusy1        (busy1),
    .oBusy2        (busy2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] er;
    logic eir;
    #1;
    g = -1;
    if (rstn)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check({tag, " ready"}, 64'(ready), 64'(er));
`ifdef REGFILE_WB_SCOREBOARD_EN
    eir = issue_valid && rstn &&
          (issue_rd == 0 || !mbusy[issue_rd] || (g >= 0 && req_addr[g] == issue_rd));
    check({tag, " busy1"}, 64'(busy1), 64'(mbusy[q1]));
    check({tag, " busy2"}, 64'(busy2), 64'(mbusy[q2]));
`else
    eir = issue_valid && rstn;
    check({tag, " busy1"}, 64'(busy1), 64'(0));
    check({tag, " busy2"}, 64'(busy2), 64'(0));
`endif
    check({tag, " issue_ready"}, 64'(issue_ready), 64'(eir));
    check({tag, " we"}, 64'(we), 64'(exp_we));
    if (exp_we) begin
      check({tag, " waddr"}, 64'(waddr), 64'(exp_addr));
      check({tag, " wdata"}, 64'(wdata), 64'(exp_data));
    end
    for (int i = 0; i < N; i++) begin
      if (rstn && req_valid[i] && g != i) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > 0) check({tag, " fair"}, 64'(wait_cnt[i] <= N - 1), 64'(1));
    end
    @(posedge clk);
    if (!rstn) begin
      ptr = 0; mbusy = '0; exp_we = 0; exp_addr = '0; exp_data = '0;
    end else begin
      exp_we = (g >= 0) && (req_addr[g] != 0);
      if (g >= 0) begin
        exp_addr = req_addr[g];
        exp_data = req_data[g];
        ptr = (g + 1) % N;
        mbusy[req_addr[g]] = 1'b0;
      end
      if (eir && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0; issue_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    issue_valid = 1'b0; issue_rd = '0; q1 = '0; q2 = '0;
    ptr = 0; mbusy = '0; exp_we = 0; exp_addr = '0; exp_data = '0; last_g = -1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(posedge clk);
    @(negedge clk);
    cycle("reset");
    #1;
    check("reset waddr", 64'(waddr), 64'(0));
    check("reset wdata", 64'(wdata), 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Single write x5 <- DEADBEEF from requester 0
    req_valid = 2'b01; req_addr[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
    cycle("single");
    idle();
    #1;
    check("single we", 64'(we), 64'(1));
    check("single addr", 64'(waddr), 64'(5));
    check("single data", 64'(wdata), 64'hDEADBEEF);
    cycle("single+1");
    cycle("single+2");

    // Realign pointer to 0, then both requesters contend for four cycles
    req_valid = 2'b10; req_addr[1] = 5'd2; req_data[1] = 32'h2222;
    cycle("align");
    req_addr[0] = 5'd10; req_data[0] = 32'hA0A0;
    req_addr[1] = 5'd11; req_data[1] = 32'hB1B1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      #1;
      check("alternate", 64'(ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      cycle("contend");
    end
    idle();
    cycle("contend+1");
    cycle("contend+2");

    // Claim x7, reclaim, then release and claim in the same cycle
    issue_valid = 1'b1; issue_rd = 5'd7; q1 = 5'd7; q2 = 5'd0;
    cycle("claim1");
    #1;
`ifdef REGFILE_WB_SCOREBOARD_EN
    check("claim2 ready", 64'(issue_ready), 64'(0));
    check("x7 busy", 64'(busy1), 64'(1));
`else
    check("claim2 ready", 64'(issue_ready), 64'(1));
    check("x7 busy", 64'(busy1), 64'(0));
`endif
    cycle("claim2");
    req_valid = 2'b01; req_addr[0] = 5'd7; req_data[0] = 32'h7777;
    #1;
    check("release+claim ready", 64'(issue_ready), 64'(1));
    cycle("release+claim");
    idle();
    #1;
`ifdef REGFILE_WB_SCOREBOARD_EN
    check("x7 still busy", 64'(busy1), 64'(1));
`else
    check("x7 still busy", 64'(busy1), 64'(0));
`endif
    cycle("after release");

    // Write to x0 is granted but suppressed
    req_valid = 2'b10; req_addr[1] = 5'd0; req_data[1] = 32'h1234; q1 = 5'd0; q2 = 5'd0;
    cycle("x0 write");
    idle();
    #1;
    check("x0 we", 64'(we), 64'(0));
    check("x0 busy", 64'(busy1), 64'(0));
    cycle("x0 write+1");

    // Claims, pointer moved, then reset with requests pending
    issue_valid = 1'b1; issue_rd = 5'd3; req_valid = 2'b01; req_addr[0] = 5'd9; req_data[0] = 32'h9;
    cycle("claim x3");
    issue_rd = 5'd4; req_valid = 2'b00;
    cycle("claim x4");
    issue_valid = 1'b0; rstn = 1'b0; req_valid = 2'b11;
    req_addr[0] = 5'd12; req_addr[1] = 5'd13;
    #1;
    check("rst ready", 64'(ready), 64'(0));
    cycle("mid reset");
    rstn = 1'b1; q1 = 5'd3; q2 = 5'd4;
    #1;
    check("post-rst grant", 64'(ready), 64'(1));
    check("post-rst we", 64'(we), 64'(0));
    check("post-rst busy3", 64'(busy1), 64'(0));
    check("post-rst busy4", 64'(busy2), 64'(0));
    cycle("post reset");

    // Randomized traffic with occasional reset
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_addr[i]  = 5'($urandom_range(0, 7));
          req_data[i]  = $urandom;
        end
      end
      issue_valid = $urandom_range(0, 1) != 0;
      issue_rd    = 5'($urandom_range(0, 7));
      q1          = 5'($urandom_range(0, 7));
      q2          = 5'($urandom_range(0, 7));
      rstn        = ($urandom_range(0, 49) != 0);
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
